// File: rtl/dual_lane_if.sv
// Bundle between the loop controller / host and the dual-lane datapath: preload, micro-op strobes, readback.
// The master side drives the strobes and the preload/readback requests; the slave side returns data and sticky errors.
interface dual_lane_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_a;
    logic [DATA_W-1:0] wr_b;
    logic [DATA_W-1:0] wr_c;
    logic              store_ab;
    logic              load_a_en;
    logic              load_b_en;
    logic              load_c_en;
    logic              mul_en;
    logic [1:0]        mul_sel;
    logic              add_en;
    logic [1:0]        add_sel;
    logic              store_c_en;
    logic [ADDR_W-1:0] index_loop;
    logic              multi;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_err;
    logic              idx_err;

    modport master (
        output we, wr_addr, wr_a, wr_b, wr_c, store_ab,
        output load_a_en, load_b_en, load_c_en, mul_en, mul_sel, add_en, add_sel, store_c_en,
        output index_loop, multi, done, rd_addr,
        input  rd_data, rd_valid, wr_err, idx_err
    );

    modport slave (
        input  we, wr_addr, wr_a, wr_b, wr_c, store_ab,
        input  load_a_en, load_b_en, load_c_en, mul_en, mul_sel, add_en, add_sel, store_c_en,
        input  index_loop, multi, done, rd_addr,
        output rd_data, rd_valid, wr_err, idx_err
    );
endinterface

// File: rtl/dual_lane_datapath.sv
// Two-lane load/mul/add/store execution datapath over register-file arrays a, b, c (lanes at i and i+1).
// Every micro-op and the readback have 1-cycle latency; no backpressure, strobes are always accepted.
module dual_lane_datapath #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic      clk,
    input  logic      rst,
    dual_lane_if.slave bus
);
    typedef logic [DATA_W-1:0] data_t;

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    data_t mem_a [DEPTH];
    data_t mem_b [DEPTH];
    data_t mem_c [DEPTH];

    data_t a_q [2];
    data_t b_q [2];
    data_t c_q [2];
    data_t p_q [2];
    data_t s_q [2];
    data_t r_q [2];

    // Lane-1 index carries an extra bit so i+1 past the top never aliases to 0.
    logic [ADDR_W:0]   idx_full [2];
    logic [ADDR_W-1:0] idx      [2];
    logic [1:0]        in_rng;
    logic [1:0]        lane_on;
    data_t             ld_a [2];
    data_t             ld_b [2];
    data_t             ld_c [2];

    logic wr_rng, rd_rng, pre_ok, pre_bad, touch, oor;

    always_comb begin
        idx_full[0] = {1'b0, bus.index_loop};
        idx_full[1] = {1'b0, bus.index_loop} + (ADDR_W+1)'(1);
        lane_on     = {bus.multi, 1'b1};
        for (int l = 0; l < 2; l++) begin
            idx[l]    = idx_full[l][ADDR_W-1:0];
            in_rng[l] = idx_full[l] < DEPTH_X;
            ld_a[l]   = in_rng[l] ? mem_a[idx[l]] : '0;
            ld_b[l]   = in_rng[l] ? mem_b[idx[l]] : '0;
            ld_c[l]   = in_rng[l] ? mem_c[idx[l]] : '0;
        end
        wr_rng  = {1'b0, bus.wr_addr} < DEPTH_X;
        rd_rng  = {1'b0, bus.rd_addr} < DEPTH_X;
        pre_ok  = bus.we && bus.store_ab && !bus.store_c_en && wr_rng;
        pre_bad = bus.we && !pre_ok;
        touch   = bus.load_a_en || bus.load_b_en || bus.load_c_en || bus.store_c_en;
        oor     = touch && ((lane_on[0] && !in_rng[0]) || (lane_on[1] && !in_rng[1]));
    end

    // Array contents survive reset; writes are only blocked while reset is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (pre_ok) begin
                mem_a[bus.wr_addr] <= bus.wr_a;
                mem_b[bus.wr_addr] <= bus.wr_b;
                mem_c[bus.wr_addr] <= bus.wr_c;
            end
            for (int l = 0; l < 2; l++) begin
                if (bus.store_c_en && lane_on[l] && in_rng[l])
                    mem_c[idx[l]] <= r_q[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < 2; l++) begin
                a_q[l] <= '0;
                b_q[l] <= '0;
                c_q[l] <= '0;
                p_q[l] <= '0;
                s_q[l] <= '0;
                r_q[l] <= '0;
            end
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            bus.wr_err   <= 1'b0;
            bus.idx_err  <= 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (lane_on[l]) begin
                    if (bus.load_a_en) a_q[l] <= ld_a[l];
                    if (bus.load_b_en) b_q[l] <= ld_b[l];
                    if (bus.load_c_en) c_q[l] <= ld_c[l];
                    if (bus.mul_en && bus.mul_sel == 2'b01)
                        p_q[l] <= b_q[l] << 1;
                    else if (bus.mul_en && bus.mul_sel == 2'b10)
                        p_q[l] <= b_q[l] + (b_q[l] << 2);
                    if (bus.add_en && bus.add_sel == 2'b10)
                        s_q[l] <= a_q[l] + p_q[l];
                    // Multiply takes priority when both ops target r.
                    if (bus.mul_en && bus.mul_sel == 2'b11)
                        r_q[l] <= c_q[l] * s_q[l];
                    else if (bus.add_en && bus.add_sel == 2'b01)
                        r_q[l] <= a_q[l] + p_q[l];
                end
            end
            bus.rd_data  <= rd_rng ? mem_c[bus.rd_addr] : '0;
            bus.rd_valid <= bus.done;
            if (pre_bad) bus.wr_err  <= 1'b1;
            if (oor)     bus.idx_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dual_lane_datapath.sv
// Directed bench for dual_lane_datapath: table of two-loop programs plus hand sequences for errors and reset.
module tb_dual_lane_datapath;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    dual_lane_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dual_lane_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] a0, b0, a1, b1, c1;
        logic        multi;
        logic [31:0] e1c0, e1c1, e2c0, e2c1;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] addr, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c);
        bus.we = 1'b1; bus.store_ab = 1'b1; bus.wr_addr = addr;
        bus.wr_a = a; bus.wr_b = b; bus.wr_c = c;
        tick();
        bus.we = 1'b0; bus.store_ab = 1'b0;
    endtask

    // ld = {load_a, load_b, load_c}; mul/add = {en, sel[1:0]}
    task automatic op(input logic [2:0] ld, input logic [2:0] mul, input logic [2:0] add, input logic st);
        {bus.load_a_en, bus.load_b_en, bus.load_c_en} = ld;
        {bus.mul_en, bus.mul_sel} = mul;
        {bus.add_en, bus.add_sel} = add;
        bus.store_c_en = st;
        tick();
        {bus.load_a_en, bus.load_b_en, bus.load_c_en} = 3'b000;
        {bus.mul_en, bus.mul_sel} = 3'b000;
        {bus.add_en, bus.add_sel} = 3'b000;
        bus.store_c_en = 1'b0;
    endtask

    // c = a + 2b
    task automatic loop1();
        op(3'b010, 3'b000, 3'b000, 1'b0);
        op(3'b100, 3'b101, 3'b000, 1'b0);
        op(3'b000, 3'b000, 3'b101, 1'b0);
        op(3'b000, 3'b000, 3'b000, 1'b1);
    endtask

    // c = c * (a + 5b)
    task automatic loop2();
        op(3'b000, 3'b110, 3'b000, 1'b0);
        op(3'b000, 3'b000, 3'b110, 1'b0);
        op(3'b001, 3'b000, 3'b000, 1'b0);
        op(3'b000, 3'b111, 3'b000, 1'b0);
        op(3'b000, 3'b000, 3'b000, 1'b1);
    endtask

    task automatic rdchk(input string name, input logic [ADDR_W-1:0] addr, input logic [31:0] exp);
        bus.done = 1'b1;
        bus.rd_addr = addr;
        tick();
        check({name, "_valid"}, {31'd0, bus.rd_valid}, 32'd1);
        check(name, bus.rd_data, exp);
    endtask

    initial begin
        bus.we = 1'b0; bus.wr_addr = '0; bus.wr_a = '0; bus.wr_b = '0; bus.wr_c = '0;
        bus.store_ab = 1'b0; bus.load_a_en = 1'b0; bus.load_b_en = 1'b0; bus.load_c_en = 1'b0;
        bus.mul_en = 1'b0; bus.mul_sel = 2'b00; bus.add_en = 1'b0; bus.add_sel = 2'b00;
        bus.store_c_en = 1'b0; bus.index_loop = '0; bus.multi = 1'b0; bus.done = 1'b0;
        bus.rd_addr = '0;

        vecs[0] = '{a0:32'd3, b0:32'd1, a1:32'd4, b1:32'd2, c1:32'd0, multi:1'b1,
                    e1c0:32'd5, e1c1:32'd8, e2c0:32'd40, e2c1:32'd112};
        vecs[1] = '{a0:32'd7, b0:32'd2, a1:32'd0, b1:32'd0, c1:32'd99, multi:1'b0,
                    e1c0:32'd11, e1c1:32'd99, e2c0:32'd187, e2c1:32'd99};
        vecs[2] = '{a0:32'hFFFF_FFFF, b0:32'd1, a1:32'd0, b1:32'd0, c1:32'd0, multi:1'b0,
                    e1c0:32'd1, e1c1:32'd0, e2c0:32'd4, e2c1:32'd0};
        vecs[3] = '{a0:32'd10, b0:32'h8000_0000, a1:32'd0, b1:32'd7, c1:32'd0, multi:1'b1,
                    e1c0:32'd10, e1c1:32'd14, e2c0:32'd100, e2c1:32'd490};

        tick();
        do_reset();
        check("rst_rd_data", bus.rd_data, 32'd0);
        check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("rst_wr_err", {31'd0, bus.wr_err}, 32'd0);
        check("rst_idx_err", {31'd0, bus.idx_err}, 32'd0);

        for (int v = 0; v < 4; v++) begin
            bus.done = 1'b0;
            do_reset();
            preload(10'd0, vecs[v].a0, vecs[v].b0, 32'd0);
            preload(10'd1, vecs[v].a1, vecs[v].b1, vecs[v].c1);
            bus.index_loop = '0;
            bus.multi = vecs[v].multi;
            loop1();
            rdchk($sformatf("v%0d_l1_c0", v), 10'd0, vecs[v].e1c0);
            rdchk($sformatf("v%0d_l1_c1", v), 10'd1, vecs[v].e1c1);
            loop2();
            rdchk($sformatf("v%0d_l2_c0", v), 10'd0, vecs[v].e2c0);
            rdchk($sformatf("v%0d_l2_c1", v), 10'd1, vecs[v].e2c1);
            check($sformatf("v%0d_idx_err", v), {31'd0, bus.idx_err}, 32'd0);
        end

        bus.done = 1'b0;
        tick();
        check("valid_drop", {31'd0, bus.rd_valid}, 32'd0);

        // Rejected preload must leave a, b, c untouched and latch wr_err until reset.
        do_reset();
        bus.multi = 1'b0;
        preload(10'd3, 32'h11, 32'h11, 32'h11);
        check("wr_err_clean", {31'd0, bus.wr_err}, 32'd0);
        bus.we = 1'b1; bus.store_ab = 1'b0; bus.wr_addr = 10'd3;
        bus.wr_a = 32'h55; bus.wr_b = 32'h55; bus.wr_c = 32'h55;
        tick();
        bus.we = 1'b0;
        check("wr_err_set", {31'd0, bus.wr_err}, 32'd1);
        rdchk("wr_drop_c3", 10'd3, 32'h11);
        bus.index_loop = 10'd3;
        loop1();
        rdchk("wr_drop_ab3", 10'd3, 32'h33);
        check("wr_err_sticky", {31'd0, bus.wr_err}, 32'd1);
        do_reset();
        check("wr_err_cleared", {31'd0, bus.wr_err}, 32'd0);

        // Top-index store with multi: lane 1 is out of range and must not wrap to c[0].
        bus.done = 1'b0;
        preload(10'd1023, 32'd5, 32'd1, 32'd0);
        preload(10'd0, 32'd0, 32'd0, 32'h77);
        bus.index_loop = 10'd1023;
        bus.multi = 1'b0;
        op(3'b010, 3'b000, 3'b000, 1'b0);
        op(3'b100, 3'b101, 3'b000, 1'b0);
        op(3'b000, 3'b000, 3'b101, 1'b0);
        check("idx_err_before", {31'd0, bus.idx_err}, 32'd0);
        bus.multi = 1'b1;
        op(3'b000, 3'b000, 3'b000, 1'b1);
        check("idx_err_set", {31'd0, bus.idx_err}, 32'd1);
        rdchk("top_c1023", 10'd1023, 32'd7);
        rdchk("no_wrap_c0", 10'd0, 32'h77);

        // Reset partway through loop 2: outputs clear, stored c survives, lane registers are zero.
        bus.done = 1'b0;
        do_reset();
        preload(10'd0, 32'd3, 32'd1, 32'd0);
        preload(10'd1, 32'd4, 32'd2, 32'd0);
        bus.index_loop = '0;
        bus.multi = 1'b1;
        loop1();
        bus.done = 1'b1;
        op(3'b000, 3'b110, 3'b000, 1'b0);
        op(3'b000, 3'b000, 3'b110, 1'b0);
        check("mid_valid_pre", {31'd0, bus.rd_valid}, 32'd1);
        do_reset();
        check("mid_rst_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("mid_rst_data", bus.rd_data, 32'd0);
        rdchk("mid_keep_c0", 10'd0, 32'd5);
        rdchk("mid_keep_c1", 10'd1, 32'd8);
        op(3'b000, 3'b000, 3'b000, 1'b1);
        rdchk("mid_r0_zero", 10'd0, 32'd0);
        rdchk("mid_r1_zero", 10'd1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
